// File: rtl/ber_pkg.sv
// Shared definitions for the BER checker: FSM encodings and sizing helpers.
package ber_pkg;

   localparam logic [0:0] ST_SEARCH = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // ceil(log2(n)), never below 1 so every counter has at least one bit
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      while ((64'd1 << r) < 64'(n)) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/ber_checker_if.sv
// Host-side bundle of the BER checker: per-channel tx/rx samples in, lock status and counts out.
interface ber_checker_if #(
   parameter int unsigned NCH    = 2,
   parameter int unsigned NB_SYM = 12,
   parameter int unsigned NB_DLY = 9,
   parameter int unsigned NB_CNT = 48
);

   logic                    i_en;
   logic                    i_clr;
   logic [NCH-1:0]          i_tx_bit;
   logic [NCH*NB_SYM-1:0]   i_rx_sym;
   logic [NCH-1:0]          o_lock;
   logic [NCH*NB_DLY-1:0]   o_delay;
   logic [NCH*NB_CNT-1:0]   o_bit_cnt;
   logic [NCH*NB_CNT-1:0]   o_err_cnt;

   modport master (
      output i_en, i_clr, i_tx_bit, i_rx_sym,
      input  o_lock, o_delay, o_bit_cnt, o_err_cnt
   );

   modport slave (
      input  i_en, i_clr, i_tx_bit, i_rx_sym,
      output o_lock, o_delay, o_bit_cnt, o_err_cnt
   );

endinterface

// File: rtl/ber_checker_ch.sv
// One BER channel: tx delay line, latency search / lock FSM, window and saturating bit/error counters.
module ber_checker_ch
   import ber_pkg::*;
#(
   parameter int unsigned NB_SYM     = 12,
   parameter int unsigned NB_DLY     = 9,
   parameter int unsigned NB_CNT     = 48,
   parameter int unsigned SYNC_LEN   = 128,
   parameter int unsigned LOCK_TH    = 0,
   parameter int unsigned LOSS_TH    = 32,
   parameter int unsigned NEG_IS_ONE = 1
) (
   input  logic              clk,
   input  logic              i_reset,
   input  logic              i_en,
   input  logic              i_clr,
   input  logic              i_tx_bit,
   input  logic [NB_SYM-1:0] i_rx_sym,
   output logic              o_lock,
   output logic [NB_DLY-1:0] o_delay,
   output logic [NB_CNT-1:0] o_bit_cnt,
   output logic [NB_CNT-1:0] o_err_cnt
);

   localparam int unsigned DEPTH    = 32'd1 << NB_DLY;
   localparam int unsigned WIN_W    = clog2(SYNC_LEN);
   localparam int unsigned ERR_W    = clog2(SYNC_LEN + 1);
   localparam int unsigned LOCK_SAT = (LOCK_TH > SYNC_LEN) ? SYNC_LEN : LOCK_TH;
   localparam int unsigned LOSS_SAT = (LOSS_TH > SYNC_LEN) ? SYNC_LEN : LOSS_TH;
   localparam logic [ERR_W-1:0]  LOCK_LIM = ERR_W'(LOCK_SAT);
   localparam logic [ERR_W-1:0]  LOSS_LIM = ERR_W'(LOSS_SAT);
   localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(SYNC_LEN - 1);
   localparam logic [NB_CNT-1:0] CNT_MAX  = '1;

   logic [0:0]        state, state_nxt;
   logic [NB_DLY-1:0] delay, delay_nxt;
   logic [WIN_W-1:0]  win_pos, win_pos_nxt;
   logic [ERR_W-1:0]  win_err, win_err_nxt, win_err_tot;
   logic [NB_CNT-1:0] bit_cnt, bit_cnt_nxt;
   logic [NB_CNT-1:0] err_cnt, err_cnt_nxt;
   logic [DEPTH-2:0]  dly_line, dly_line_nxt;
   logic [DEPTH-1:0]  tap;
   logic              ref_bit, rx_bit, err_bit, win_end;
   logic              unused_sym;

   // tap[0] is the current tx bit, tap[d] the bit from d strobes ago
   assign tap         = {dly_line, i_tx_bit};
   assign ref_bit     = tap[delay];
   assign rx_bit      = i_rx_sym[NB_SYM-1] ^ (NEG_IS_ONE == 0);
   assign err_bit     = rx_bit ^ ref_bit;
   assign win_end     = (win_pos == WIN_LAST);
   assign win_err_tot = win_err + ERR_W'(err_bit);
   assign unused_sym  = ^i_rx_sym[NB_SYM-2:0];

   always_comb begin
      state_nxt    = state;
      delay_nxt    = delay;
      win_pos_nxt  = win_pos;
      win_err_nxt  = win_err;
      bit_cnt_nxt  = bit_cnt;
      err_cnt_nxt  = err_cnt;
      dly_line_nxt = dly_line;
      if (i_en) begin
         dly_line_nxt = tap[DEPTH-2:0];
         win_pos_nxt  = win_end ? '0 : win_pos + WIN_W'(1);
         win_err_nxt  = win_end ? '0 : win_err_tot;
         // counters freeze together once bit_cnt saturates, keeping the ratio meaningful
         if ((state == ST_LOCKED) && (bit_cnt != CNT_MAX)) begin
            bit_cnt_nxt = bit_cnt + NB_CNT'(1);
            if (err_cnt != CNT_MAX) err_cnt_nxt = err_cnt + NB_CNT'(err_bit);
         end
         if (win_end) begin
            if (state == ST_SEARCH) begin
               if (win_err_tot <= LOCK_LIM) state_nxt = ST_LOCKED;
               else                         delay_nxt = delay + NB_DLY'(1);
            end else if (win_err_tot > LOSS_LIM) begin
               state_nxt = ST_SEARCH;
               delay_nxt = delay + NB_DLY'(1);
            end
         end
      end
      // clear beats a coincident strobe; window bookkeeping above is unaffected
      if (i_clr) begin
         bit_cnt_nxt = '0;
         err_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state    <= ST_SEARCH;
         delay    <= '0;
         win_pos  <= '0;
         win_err  <= '0;
         bit_cnt  <= '0;
         err_cnt  <= '0;
         dly_line <= '0;
      end else begin
         state    <= state_nxt;
         delay    <= delay_nxt;
         win_pos  <= win_pos_nxt;
         win_err  <= win_err_nxt;
         bit_cnt  <= bit_cnt_nxt;
         err_cnt  <= err_cnt_nxt;
         dly_line <= dly_line_nxt;
      end
   end

   assign o_lock    = (state == ST_LOCKED);
   assign o_delay   = delay;
   assign o_bit_cnt = bit_cnt;
   assign o_err_cnt = err_cnt;

endmodule

// File: rtl/ber_checker.sv
// Multi-channel BER checker top: one independent checker per channel, sliced from the shared bus.
module ber_checker
   import ber_pkg::*;
#(
   parameter int unsigned NCH        = 2,
   parameter int unsigned NB_SYM     = 12,
   parameter int unsigned NB_DLY     = 9,
   parameter int unsigned NB_CNT     = 48,
   parameter int unsigned SYNC_LEN   = 128,
   parameter int unsigned LOCK_TH    = 0,
   parameter int unsigned LOSS_TH    = 32,
   parameter int unsigned NEG_IS_ONE = 1
) (
   input logic          clk,
   input logic          i_reset,
   ber_checker_if.slave bus
);

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      ber_checker_ch #(
         .NB_SYM     (NB_SYM),
         .NB_DLY     (NB_DLY),
         .NB_CNT     (NB_CNT),
         .SYNC_LEN   (SYNC_LEN),
         .LOCK_TH    (LOCK_TH),
         .LOSS_TH    (LOSS_TH),
         .NEG_IS_ONE (NEG_IS_ONE)
      ) u_ch (
         .clk       (clk),
         .i_reset   (i_reset),
         .i_en      (bus.i_en),
         .i_clr     (bus.i_clr),
         .i_tx_bit  (bus.i_tx_bit[k]),
         .i_rx_sym  (bus.i_rx_sym[k*NB_SYM +: NB_SYM]),
         .o_lock    (bus.o_lock[k]),
         .o_delay   (bus.o_delay[k*NB_DLY +: NB_DLY]),
         .o_bit_cnt (bus.o_bit_cnt[k*NB_CNT +: NB_CNT]),
         .o_err_cnt (bus.o_err_cnt[k*NB_CNT +: NB_CNT])
      );
   end

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: default build for acquisition/lock/loss/clear, small build for wrap and saturation.
module tb_ber_checker;

   logic clk = 1'b0;
   logic rst;
   logic rst8;
   always #5 clk = ~clk;

   ber_checker_if #(.NCH(2), .NB_SYM(12), .NB_DLY(9), .NB_CNT(48)) bus0 ();
   ber_checker_if #(.NCH(2), .NB_SYM(12), .NB_DLY(9), .NB_CNT(8))  bus8 ();

   ber_checker u_dut (
      .clk     (clk),
      .i_reset (rst),
      .bus     (bus0)
   );

   ber_checker #(.NB_CNT(8), .SYNC_LEN(16)) u_dut8 (
      .clk     (clk),
      .i_reset (rst8),
      .bus     (bus8)
   );

   int n_chk = 0;
   int n_bad = 0;

   logic [8:0]   p9 [2];
   logic [511:0] hist0 [2];
   int           dly0 [2];
   logic [14:0]  gs;
   int           gerr;
   logic [14:0]  p15;
   logic [8:0]   q9;
   logic [511:0] hist8;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk0(input string tag, input int c, input logic lk, input int dl,
                       input longint unsigned bc, input longint unsigned ec);
      check($sformatf("%s_lock%0d", tag, c), 64'(bus0.o_lock[c]), 64'(lk));
      check($sformatf("%s_dly%0d", tag, c), 64'(bus0.o_delay[c*9 +: 9]), 64'(dl));
      check($sformatf("%s_bits%0d", tag, c), 64'(bus0.o_bit_cnt[c*48 +: 48]), 64'(bc));
      check($sformatf("%s_errs%0d", tag, c), 64'(bus0.o_err_cnt[c*48 +: 48]), 64'(ec));
   endtask

   task automatic chk8(input string tag, input int c, input logic lk, input int dl,
                       input int unsigned bc, input int unsigned ec);
      check($sformatf("%s_lock%0d", tag, c), 64'(bus8.o_lock[c]), 64'(lk));
      check($sformatf("%s_dly%0d", tag, c), 64'(bus8.o_delay[c*9 +: 9]), 64'(dl));
      check($sformatf("%s_bits%0d", tag, c), 64'(bus8.o_bit_cnt[c*8 +: 8]), 64'(bc));
      check($sformatf("%s_errs%0d", tag, c), 64'(bus8.o_err_cnt[c*8 +: 8]), 64'(ec));
   endtask

   // PRBS9 tx on both channels; rx is tx delayed dly0[c] (optionally flipped) or PRBS15 garbage
   task automatic step0(input logic en, input logic clr, input logic [1:0] flip, input logic [1:0] garb);
      logic        b;
      logic        r;
      logic [1:0]  tx;
      logic [23:0] rx;
      for (int c = 0; c < 2; c++) begin
         if (en) begin
            b = p9[c][8] ^ p9[c][4];
            p9[c] = {p9[c][7:0], b};
            hist0[c] = {hist0[c][510:0], b};
         end
         tx[c] = hist0[c][0];
         if (garb[c]) begin
            if (en) begin
               b = gs[14] ^ gs[13];
               gs = {gs[13:0], b};
            end
            r = gs[0];
            if (en && (r != hist0[c][dly0[c]])) gerr++;
         end else begin
            r = hist0[c][dly0[c]] ^ flip[c];
         end
         rx[c*12 +: 12] = r ? 12'hF00 : 12'h100;
      end
      bus0.i_en     = en;
      bus0.i_clr    = clr;
      bus0.i_tx_bit = tx;
      bus0.i_rx_sym = rx;
      @(posedge clk);
      #1;
   endtask

   // ch0: PRBS15 tx, rx delayed 511; ch1: PRBS9 tx against a constant +256 symbol
   task automatic step8(input logic flip);
      logic b15;
      logic b9;
      b15 = p15[14] ^ p15[13];
      p15 = {p15[13:0], b15};
      hist8 = {hist8[510:0], b15};
      b9 = q9[8] ^ q9[4];
      q9 = {q9[7:0], b9};
      bus8.i_en     = 1'b1;
      bus8.i_clr    = 1'b0;
      bus8.i_tx_bit = {b9, b15};
      bus8.i_rx_sym = {12'h100, (hist8[511] ^ flip) ? 12'hF00 : 12'h100};
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic   dropped;
      longint exp_err;

      rst  = 1'b1;
      rst8 = 1'b1;
      bus8.i_en = 1'b0; bus8.i_clr = 1'b0; bus8.i_tx_bit = '0; bus8.i_rx_sym = '0;
      p9[0] = 9'h1FF; p9[1] = 9'h0A5;
      gs = 15'h7FFF; p15 = 15'h1234; q9 = 9'h155;
      hist0[0] = '0; hist0[1] = '0; hist8 = '0;
      dly0[0] = 0; dly0[1] = 0; gerr = 0;

      step0(1'b0, 1'b0, 2'b00, 2'b00);
      step0(1'b0, 1'b0, 2'b00, 2'b00);
      for (int c = 0; c < 2; c++) chk0("reset", c, 1'b0, 0, 0, 0);
      rst = 1'b0;

      // acquisition at latency 37
      dly0[0] = 37; dly0[1] = 37;
      repeat (38*128 - 1) step0(1'b1, 1'b0, 2'b00, 2'b00);
      for (int c = 0; c < 2; c++) begin
         check($sformatf("prelock_lock%0d", c), 64'(bus0.o_lock[c]), 64'd0);
         check($sformatf("prelock_dly%0d", c), 64'(bus0.o_delay[c*9 +: 9]), 64'd37);
      end
      step0(1'b1, 1'b0, 2'b00, 2'b00);
      for (int c = 0; c < 2; c++) chk0("lock37", c, 1'b1, 37, 0, 0);
      repeat (1000) step0(1'b1, 1'b0, 2'b00, 2'b00);
      for (int c = 0; c < 2; c++) chk0("run1000", c, 1'b1, 37, 1000, 0);
      repeat (3) step0(1'b0, 1'b0, 2'b00, 2'b00);
      for (int c = 0; c < 2; c++) chk0("en_low", c, 1'b1, 37, 1000, 0);

      // clear with a coincident strobe, then one counted strobe
      step0(1'b1, 1'b1, 2'b00, 2'b00);
      for (int c = 0; c < 2; c++) chk0("clr", c, 1'b1, 37, 0, 0);
      step0(1'b1, 1'b0, 2'b00, 2'b00);
      for (int c = 0; c < 2; c++) chk0("post_clr", c, 1'b1, 37, 1, 0);

      // reset while locked
      rst = 1'b1;
      step0(1'b1, 1'b0, 2'b00, 2'b00);
      for (int c = 0; c < 2; c++) chk0("rst_lock", c, 1'b0, 0, 0, 0);
      rst = 1'b0;
      hist0[0] = '0; hist0[1] = '0;

      // lock at latency 5, then one bit error every 10 symbols
      dly0[0] = 5; dly0[1] = 5;
      repeat (6*128 - 1) step0(1'b1, 1'b0, 2'b00, 2'b00);
      check("prelock5_lock0", 64'(bus0.o_lock[0]), 64'd0);
      step0(1'b1, 1'b0, 2'b00, 2'b00);
      for (int c = 0; c < 2; c++) chk0("lock5", c, 1'b1, 5, 0, 0);
      dropped = 1'b0;
      for (int k = 1; k <= 10000; k++) begin
         step0(1'b1, 1'b0, (k % 10 == 0) ? 2'b11 : 2'b00, 2'b00);
         if (bus0.o_lock !== 2'b11) dropped = 1'b1;
      end
      check("lock_held", 64'(dropped), 64'd0);
      for (int c = 0; c < 2; c++) chk0("flip", c, 1'b1, 5, 10000, 1000);

      // finish the window, then one full window of garbage on ch0
      repeat (112) step0(1'b1, 1'b0, 2'b00, 2'b00);
      gerr = 0;
      repeat (127) step0(1'b1, 1'b0, 2'b00, 2'b01);
      check("preloss_lock0", 64'(bus0.o_lock[0]), 64'd1);
      step0(1'b1, 1'b0, 2'b00, 2'b01);
      exp_err = 1000 + longint'(gerr);
      chk0("loss", 0, 1'b0, 6, 10240, exp_err);
      chk0("indep", 1, 1'b1, 5, 10240, 1000);
      repeat (200) step0(1'b1, 1'b0, 2'b00, 2'b01);
      chk0("resume", 0, 1'b0, 7, 10240, exp_err);
      bus0.i_en = 1'b0;

      // small build: wrap-around acquisition at 511 and counter saturation
      for (int c = 0; c < 2; c++) chk8("rst8", c, 1'b0, 0, 0, 0);
      rst8 = 1'b0;
      repeat (512*16 - 1) step8(1'b0);
      chk8("pre511", 0, 1'b0, 511, 0, 0);
      chk8("pre511", 1, 1'b0, 511, 0, 0);
      step8(1'b0);
      chk8("lock511", 0, 1'b1, 511, 0, 0);
      chk8("sweep", 1, 1'b0, 0, 0, 0);
      for (int k = 1; k <= 255; k++) step8(k % 10 == 0);
      chk8("sat", 0, 1'b1, 511, 255, 25);
      for (int k = 256; k <= 275; k++) step8(k % 10 == 0);
      chk8("sat_hold", 0, 1'b1, 511, 255, 25);
      chk8("sweep2", 1, 1'b0, 17, 0, 0);
      bus8.i_en = 1'b0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
